prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 121 ++++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-serial program loader for a 16-bit instruction memory.
// Assembles big-endian byte pairs into instruction words, writes them at
// even byte addresses starting from 0, and holds the CPU until the load
// finishes (halt word 16'hFFFF written, or MAX_WORDS words written).
//
// Ports
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   one-cycle pulse, begins a load (honoured in IDLE/DONE)
//   in_valid    in   in_byte carries a valid program byte
//   in_byte     in   program byte, high byte of each instruction first
//   in_ready    out  loader accepts in_byte this cycle
//   mem_we      out  instruction-memory write strobe
//   mem_addr    out  instruction-memory byte address (even)
//   mem_wdata   out  instruction word to write
//   cpu_hold    out  keeps the CPU parked at PC 0 while high
//   done        out  load complete
//   word_count  out  words written in the current or last load
//
// state | meaning
// IDLE  | after reset, waiting for start, CPU held
// HI    | waiting for the high byte of the next word
// LO    | waiting for the low byte of the next word
// WRITE | one-cycle memory write of the assembled word
// DONE  | load finished, CPU released, start reloads
module prog_loader #(
   parameter int MAX_WORDS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic [15:0] word_count
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] HI    = 3'd1;
   localparam logic [2:0] LO    = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [15:0] MAX_W   = 16'(MAX_WORDS);
   localparam logic [15:0] HALT_W  = 16'hFFFF;

   logic [2:0]  state_q, state_d;
   logic [15:0] addr_q,  addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] count_q, count_d;
   logic [15:0] count_inc;

   assign count_inc = count_q + 16'd1;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = HI;
               addr_d  = 16'd0;
               count_d = 16'd0;
            end
         end
         HI: begin
            if (in_valid) begin
               wdata_d[15:8] = in_byte;
               state_d       = LO;
            end
         end
         LO: begin
            if (in_valid) begin
               wdata_d[7:0] = in_byte;
               state_d      = WRITE;
            end
         end
         WRITE: begin
            // The halt word is written and counted before stopping.
            addr_d  = addr_q + 16'd2;
            count_d = count_inc;
            if ((wdata_q == HALT_W) || (count_inc == MAX_W)) begin
               state_d = DONE;
            end else begin
               state_d = HI;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 16'd0;
         wdata_q <= 16'd0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
      end
   end

   assign in_ready   = (state_q == HI) || (state_q == LO);
   assign mem_we     = (state_q == WRITE);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_hold   = (state_q != DONE);
   assign done       = (state_q == DONE);
   assign word_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader. One instance uses the
// default capacity, a second uses MAX_WORDS=4 for the capacity stop.
module tb_prog_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        start = 1'b0, in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_ready, mem_we, cpu_hold, done;
   logic [15:0] mem_addr, mem_wdata, word_count;

   logic        start4 = 1'b0, in_valid4 = 1'b0;
   logic [7:0]  in_byte4 = 8'h00;
   logic        in_ready4, mem_we4, cpu_hold4, done4;
   logic [15:0] mem_addr4, mem_wdata4, word_count4;

   int checks = 0;
   int errors = 0;

   logic [15:0] wa[$], wd[$], wa4[$], wd4[$];

   always #5 clock = ~clock;

   prog_loader dut (
      .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
      .in_byte(in_byte), .in_ready(in_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
      .done(done), .word_count(word_count)
   );

   prog_loader #(.MAX_WORDS(4)) dut4 (
      .clock(clock), .reset(reset), .start(start4), .in_valid(in_valid4),
      .in_byte(in_byte4), .in_ready(in_ready4), .mem_we(mem_we4),
      .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .cpu_hold(cpu_hold4),
      .done(done4), .word_count(word_count4)
   );

   // Write log, sampled mid-cycle; each WRITE state spans one negedge.
   always @(negedge clock) begin
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
      end
      if (mem_we4) begin
         wa4.push_back(mem_addr4);
         wd4.push_back(mem_wdata4);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic sel, input int idx,
                         input logic [15:0] ea, input logic [15:0] ed);
      logic [31:0] obs;
      if (!sel) obs = (idx < wa.size())  ? {wa[idx],  wd[idx]}  : 32'hxxxxxxxx;
      else      obs = (idx < wa4.size()) ? {wa4[idx], wd4[idx]} : 32'hxxxxxxxx;
      chk(tag, obs, {ea, ed});
   endtask

   // Present one byte after 'gap' idle cycles and hold it until consumed.
   task automatic feed(input logic sel, input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      for (int g = 0; g < gap; g++) step();
      if (!sel) begin in_valid = 1'b1; in_byte = b; end
      else      begin in_valid4 = 1'b1; in_byte4 = b; end
      for (int k = 0; k < 20; k++) begin
         if ((!sel && in_ready) || (sel && in_ready4)) begin
            step();
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!sel) in_valid = 1'b0; else in_valid4 = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL feed_timeout observed=no_accept expected=accept byte=%h", b);
      end
   endtask

   task automatic pulse_start(input logic sel);
      if (!sel) start = 1'b1; else start4 = 1'b1;
      step();
      start = 1'b0;
      start4 = 1'b0;
   endtask

   int base;

   initial begin
      // Reset state
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_word_count", word_count, 0);
      chk("rst_done", done, 0);
      chk("rst_cpu_hold", cpu_hold, 1);
      reset = 1'b0;

      // in_valid in IDLE is not consumed
      in_valid = 1'b1; in_byte = 8'h55;
      step(); step(); step();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_no_write", wa.size(), 0);
      in_valid = 1'b0;

      // Basic load, in_valid continuously high
      pulse_start(0);
      chk("basic_hi_ready", in_ready, 1);
      chk("basic_addr0", mem_addr, 0);
      chk("basic_cnt0", word_count, 0);
      feed(0, 8'h71, 0); feed(0, 8'h0F, 0);
      chk("basic_write_we", mem_we, 1);
      chk("basic_write_ready", in_ready, 0);
      feed(0, 8'h25, 0); feed(0, 8'h07, 0);
      feed(0, 8'hFF, 0); feed(0, 8'hFF, 0);
      chk("basic_last_addr", mem_addr, 16'h0004);
      chk("basic_last_data", mem_wdata, 16'hFFFF);
      step();
      chk("basic_done", done, 1);
      chk("basic_cpu_hold", cpu_hold, 0);
      chk("basic_word_count", word_count, 3);
      chk("basic_ready_done", in_ready, 0);
      chk("basic_nwrites", wa.size(), 3);
      chk_wr("basic_w0", 0, 0, 16'h0000, 16'h710F);
      chk_wr("basic_w1", 0, 1, 16'h0002, 16'h2507);
      chk_wr("basic_w2", 0, 2, 16'h0004, 16'hFFFF);

      // Reload from DONE
      base = wa.size();
      pulse_start(0);
      chk("reload_done_low", done, 0);
      chk("reload_hold_high", cpu_hold, 1);
      chk("reload_addr0", mem_addr, 0);
      chk("reload_cnt0", word_count, 0);
      feed(0, 8'h01, 0); feed(0, 8'h01, 0);
      feed(0, 8'hFF, 0); feed(0, 8'hFF, 0);
      step();
      chk("reload_done", done, 1);
      chk("reload_word_count", word_count, 2);
      chk("reload_nwrites", wa.size() - base, 2);
      chk_wr("reload_w0", 0, base, 16'h0000, 16'h0101);
      chk_wr("reload_w1", 0, base + 1, 16'h0002, 16'hFFFF);

      // Back-pressure: one idle cycle before every byte
      base = wa.size();
      pulse_start(0);
      feed(0, 8'h71, 1); feed(0, 8'h0F, 1);
      feed(0, 8'h25, 1); feed(0, 8'h07, 1);
      feed(0, 8'hFF, 1); feed(0, 8'hFF, 1);
      step();
      chk("bp_done", done, 1);
      chk("bp_word_count", word_count, 3);
      chk("bp_nwrites", wa.size() - base, 3);
      chk_wr("bp_w0", 0, base, 16'h0000, 16'h710F);
      chk_wr("bp_w1", 0, base + 1, 16'h0002, 16'h2507);
      chk_wr("bp_w2", 0, base + 2, 16'h0004, 16'hFFFF);

      // start ignored during LO
      base = wa.size();
      pulse_start(0);
      feed(0, 8'h12, 0);
      pulse_start(0);
      chk("lo_start_ready", in_ready, 1);
      feed(0, 8'h34, 0);
      chk("lo_start_we", mem_we, 1);
      chk("lo_start_wdata", mem_wdata, 16'h1234);
      chk("lo_start_addr", mem_addr, 0);
      step();
      chk("lo_start_cnt", word_count, 1);

      // Reset mid-word, with start and in_valid also asserted
      feed(0, 8'h13, 0);
      reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_byte = 8'h99;
      step();
      reset = 1'b0; start = 1'b0;
      chk("midrst_ready", in_ready, 0);
      chk("midrst_hold", cpu_hold, 1);
      chk("midrst_cnt", word_count, 0);
      chk("midrst_addr", mem_addr, 0);
      chk("midrst_wdata", mem_wdata, 0);
      step(); step();
      chk("midrst_needs_start", in_ready, 0);
      in_valid = 1'b0;
      chk("midrst_nwrites", wa.size() - base, 1);
      pulse_start(0);
      feed(0, 8'hAB, 0); feed(0, 8'hCD, 0);
      step();
      chk("midrst_nwrites2", wa.size() - base, 2);
      chk_wr("midrst_w", 0, base + 1, 16'h0000, 16'hABCD);
      chk("midrst_cnt1", word_count, 1);

      // Capacity stop on the MAX_WORDS=4 instance
      pulse_start(1);
      for (int i = 0; i < 4; i++) begin
         feed(1, 8'h10, 0);
         feed(1, 8'(8'h20 + i), 0);
      end
      step();
      chk("cap_done", done4, 1);
      chk("cap_cnt", word_count4, 4);
      chk("cap_ready", in_ready4, 0);
      in_valid4 = 1'b1; in_byte4 = 8'h10;
      for (int i = 0; i < 6; i++) step();
      chk("cap_ready_held", in_ready4, 0);
      in_valid4 = 1'b0;
      chk("cap_nwrites", wa4.size(), 4);
      chk_wr("cap_w0", 1, 0, 16'h0000, 16'h1020);
      chk_wr("cap_w1", 1, 1, 16'h0002, 16'h1021);
      chk_wr("cap_w2", 1, 2, 16'h0004, 16'h1022);
      chk_wr("cap_w3", 1, 3, 16'h0006, 16'h1023);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
